// File: rtl/cpu_sequencer.sv
// Three-cycle (FETCH/DECODE/EXEC) instruction sequencer for the 4-bit X/Y/Z/ULA datapath.
// Decodes 8-bit ROM words into one-cycle registered function codes with a start/busy/done handshake.
module cpu_sequencer #(
    parameter int          ADDR_W    = 4,
    parameter logic [2:0]  REG_HOLD  = 3'd0,
    parameter logic [2:0]  REG_LOAD  = 3'd1,
    parameter logic [2:0]  REG_CLEAR = 3'd2,
    parameter logic [2:0]  REG_SHR   = 3'd3,
    parameter logic [2:0]  REG_SHL   = 3'd4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rom_data,
    input  logic              y_zero,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [3:0]        imm,
    output logic [2:0]        Tx,
    output logic [2:0]        Ty,
    output logic [2:0]        Tz,
    output logic [2:0]        Tula,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDX  = 4'h1;
    localparam logic [3:0] OP_ALU  = 4'h2;
    localparam logic [3:0] OP_MVZ  = 4'h3;
    localparam logic [3:0] OP_CLR  = 4'h4;
    localparam logic [3:0] OP_SHY  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;

    // Jump operands are 4 bits wide regardless of the PC width.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [3:0] operand);
        return ADDR_W'(operand);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'h8) && (op <= 4'hE);
    endfunction

    assign rom_addr = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= 8'h00;
            imm     <= 4'h0;
            Tx      <= REG_HOLD;
            Ty      <= REG_HOLD;
            Tz      <= REG_HOLD;
            Tula    <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            // Codes and done are single-cycle strobes; they fall back every cycle unless re-asserted.
            Tx   <= REG_HOLD;
            Ty   <= REG_HOLD;
            Tz   <= REG_HOLD;
            Tula <= 3'd0;
            done <= 1'b0;

            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc      <= '0;
                        illegal <= 1'b0;
                        busy    <= 1'b1;
                        state   <= S_FETCH;
                    end
                end

                S_FETCH: state <= S_DECODE;

                S_DECODE: begin
                    ir <= rom_data;
                    if (rom_data[7:4] == OP_HALT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_HALTED;
                    end else begin
                        state <= S_EXEC;
                    end
                    case (rom_data[7:4])
                        OP_LDX: begin
                            imm <= rom_data[3:0];
                            Tx  <= REG_LOAD;
                        end
                        OP_ALU: begin
                            Tula <= rom_data[2:0];
                            Ty   <= REG_LOAD;
                        end
                        OP_MVZ: Tz <= REG_LOAD;
                        OP_CLR: begin
                            Tx <= REG_CLEAR;
                            Ty <= REG_CLEAR;
                            Tz <= REG_CLEAR;
                        end
                        OP_SHY: Ty <= rom_data[0] ? REG_SHL : REG_SHR;
                        default: ;
                    endcase
                end

                S_EXEC: begin
                    state <= S_FETCH;
                    case (ir[7:4])
                        OP_JMP: pc <= jump_target(ir[3:0]);
                        OP_JZ:  pc <= y_zero ? jump_target(ir[3:0]) : pc + ADDR_W'(1);
                        default: pc <= pc + ADDR_W'(1);
                    endcase
                    if (is_illegal(ir[7:4])) begin
                        illegal <= 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic unused_nop;
    assign unused_nop = (OP_NOP == 4'h0);

endmodule
